pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline hazard scheduler for the five-stage core: the single block that decides, every cycle, which stages hold (stall), which pipeline registers are loaded with bubbles (flush), and when the PC is redirected. It arbitrates between the IF and MEM stall requests, the ID load-use hazard and the EX-stage jump/branch resolution. Redirects are registered and can be deferred while an instruction fetch is outstanding. It sits beside the stage registers and drives pc_reg, if_id, id_ex, ex_mem and mem_wb.

## Interface
- AddrLen, 32, PC/target width.
- CntLen, 32, width of the performance counters (only present with PIPE_CTRL_PERF_EN).

- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_if  in  1  IF cannot deliver an instruction this cycle.
- if_busy  in  1  IF has a fetch outstanding and cannot accept a PC redirect.
- stallreq_mem  in  1  MEM cannot complete this cycle.
- stallreq_ld  in  1  ID consumes rd of a load currently in EX (load-use hazard).
- ex_jump_flag  in  1  EX resolved a taken jump/branch.
- ex_jump_addr  in  AddrLen  target for ex_jump_flag.
- stall  out  6  hold per stage: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] reserved (always 0).
- flush  out  6  load a bubble this edge, same bit mapping; flush wins over stall for the same bit.
- redirect_valid  out  1  PC loads redirect_addr this edge.
- redirect_addr  out  AddrLen  registered redirect target.
- stall_cycles, flush_count  out  CntLen  perf counters (PIPE_CTRL_PERF_EN only).

## Operation
- States: IDLE, WAIT (jump accepted, IF busy), REDIR (redirect issued).
- Priority, highest first: stallreq_mem, jump acceptance / WAIT / REDIR, stallreq_ld, stallreq_if.
- stallreq_mem: stall = 6'b011111, flush = 0. No jump is accepted, and the state does not advance. In WAIT, the if_busy exit check still evaluates.
- Jump accept: in IDLE, when ex_jump_flag=1 and stallreq_mem=0. The block sets flush[1]=flush[2]=1, which kills the wrong-path instructions in IF/ID and ID/EX, and latches ex_jump_addr into target_q.
  - if_busy=0: next state REDIR.
  - if_busy=1: next state WAIT.
- WAIT: stall[0]=1, flush[1]=flush[2]=1, ex_jump_flag ignored. Exits to REDIR on the first edge with if_busy=0.
- REDIR: redirect_valid=1, redirect_addr=target_q, flush[1]=1, ex_jump_flag ignored. Next state IDLE.
- stallreq_ld (IDLE, no jump accepted): stall = 6'b000111, flush[2]=1, which inserts a bubble into EX.
- stallreq_if (IDLE, nothing above active): stall = 6'b000011, flush = 0.
- When ex_jump_flag and stallreq_ld are both asserted, the jump wins.
- stall and flush are combinational from the state and the current inputs. redirect_valid and redirect_addr depend only on the state and target_q.

## Timing
- Reset (rst=0, async): state IDLE, target_q=0, redirect_valid=0, redirect_addr=0, stall=0, flush=0, counters=0.
- Jump latency, if_busy=0: accept at edge N (flushes take effect) → redirect_valid high during cycle N+1 → PC = target after edge N+1.
- Jump latency, if_busy=1: redirect is asserted the cycle after the edge that sees if_busy=0.
- redirect_valid is high for exactly one cycle per accepted jump.
- Reset mid-WAIT/REDIR: the pending target is discarded and no redirect is issued.
- A held ex_jump_flag under stallreq_mem is accepted on the first cycle without a MEM stall, exactly once.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cycles: +1 on each edge with any stall bit set.
  - flush_count: +1 per accepted jump.
  - Both are CntLen wide and saturate at all-ones.
- PIPE_CTRL_PERF_EN undefined: the counters and their ports are absent. No other behaviour changes.

## Test plan
- Jump, IF idle: ex_jump_flag=1, ex_jump_addr=0x100, if_busy=0 → that cycle flush=6'b000110; next cycle redirect_valid=1, addr=0x100, flush=6'b000010; then IDLE.
- Jump, IF busy 3 cycles: as above with if_busy=1 for 3 cycles → stall[0]=1 and flush=6'b000110 throughout; redirect_valid appears one cycle after if_busy falls, exactly once.
- MEM stall over jump: stallreq_mem=1 for 2 cycles with ex_jump_flag=1 → stall=6'b011111, no flush; acceptance on cycle 3, then redirect on cycle 4.
- Load-use: stallreq_ld=1 one cycle → stall=6'b000111, flush=6'b000100. With ex_jump_flag also 1 → jump path only.
- Async reset in WAIT: drop rst mid-cycle → all outputs 0 immediately; no redirect after release.
- PERF_EN: 5 stall cycles plus 2 jumps → stall_cycles=5 (plus cycles stalled by the jumps), flush_count=2. Preloaded counter at all-ones stays at all-ones.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the hazard scheduler and the five pipeline stages.
// PIPE_CTRL_PERF_EN adds the performance-counter signals.
interface pipe_ctrl_if #(
  parameter int AddrLen = 32
`ifdef PIPE_CTRL_PERF_EN
  , parameter int CntLen = 32
`endif
);
  logic               stallreq_if;
  logic               if_busy;
  logic               stallreq_mem;
  logic               stallreq_ld;
  logic               ex_jump_flag;
  logic [AddrLen-1:0] ex_jump_addr;
  logic [5:0]         stall;
  logic [5:0]         flush;
  logic               redirect_valid;
  logic [AddrLen-1:0] redirect_addr;
`ifdef PIPE_CTRL_PERF_EN
  logic [CntLen-1:0]  stall_cycles;
  logic [CntLen-1:0]  flush_count;
`endif

  // master: the scheduler; slave: the stage registers it controls
  modport master (
    input  stallreq_if, if_busy, stallreq_mem, stallreq_ld, ex_jump_flag, ex_jump_addr,
`ifdef PIPE_CTRL_PERF_EN
    output stall_cycles, flush_count,
`endif
    output stall, flush, redirect_valid, redirect_addr
  );

  modport slave (
    output stallreq_if, if_busy, stallreq_mem, stallreq_ld, ex_jump_flag, ex_jump_addr,
`ifdef PIPE_CTRL_PERF_EN
    input  stall_cycles, flush_count,
`endif
    input  stall, flush, redirect_valid, redirect_addr
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard scheduler: per-stage stall/flush and registered PC redirect.
// Optional PIPE_CTRL_PERF_EN adds saturating stall_cycles / flush_count counters.
module pipe_ctrl #(
  parameter int AddrLen = 32
`ifdef PIPE_CTRL_PERF_EN
  , parameter int CntLen = 32
`endif
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, REDIR} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [AddrLen-1:0] r_target;
  logic               w_accept;
  logic [5:0]         w_stall;
  logic [5:0]         w_flush;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_stall      = 6'b000000;
    w_flush      = 6'b000000;
    if (bus.stallreq_mem) begin
      // A pending redirect is held while the PC is frozen; only the WAIT exit still advances.
      w_stall = 6'b011111;
      if (r_state == WAIT && !bus.if_busy)
        w_state_next = REDIR;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.ex_jump_flag) begin
            w_accept     = 1'b1;
            w_flush      = 6'b000110;
            w_state_next = bus.if_busy ? WAIT : REDIR;
          end else if (bus.stallreq_ld) begin
            w_stall = 6'b000111;
            w_flush = 6'b000100;
          end else if (bus.stallreq_if) begin
            w_stall = 6'b000011;
          end
        end
        WAIT: begin
          w_stall = 6'b000001;
          w_flush = 6'b000110;
          if (!bus.if_busy)
            w_state_next = REDIR;
        end
        REDIR: begin
          w_flush      = 6'b000010;
          w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
    if (!rst) begin
      w_stall = 6'b000000;
      w_flush = 6'b000000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_target <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept)
        r_target <= bus.ex_jump_addr;
    end
  end

  assign bus.stall          = w_stall;
  assign bus.flush          = w_flush;
  assign bus.redirect_valid = (r_state == REDIR);
  assign bus.redirect_addr  = r_target;

`ifdef PIPE_CTRL_PERF_EN
  logic [CntLen-1:0] r_stall_cycles;
  logic [CntLen-1:0] r_flush_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if ((|w_stall) && (r_stall_cycles != {CntLen{1'b1}}))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_accept && (r_flush_count != {CntLen{1'b1}}))
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus randomized bench for pipe_ctrl, checked against a behavioural model
// that tracks the outstanding redirect as two flags and a target.
module tb_pipe_ctrl;
  localparam int ADDR_LEN = 32;
  localparam int CNT_LEN  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_if #(.AddrLen(ADDR_LEN), .CntLen(CNT_LEN)) pif ();
  pipe_ctrl #(.AddrLen(ADDR_LEN), .CntLen(CNT_LEN)) dut (.clk(clk), .rst(rst), .bus(pif));
`else
  pipe_ctrl_if #(.AddrLen(ADDR_LEN)) pif ();
  pipe_ctrl #(.AddrLen(ADDR_LEN)) dut (.clk(clk), .rst(rst), .bus(pif));
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // model: a jump waiting for IF, a redirect being presented, and the target
  bit              m_wait_if;
  bit              m_redirecting;
  logic [31:0]     m_tgt;
  int              m_stall_cnt;
  int              m_jump_cnt;
  logic [5:0]      e_stall, e_flush;
  logic [5:0]      o_stall, o_flush;
  logic            o_rv;
  logic [31:0]     o_ra;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait_if     = 1'b0;
    m_redirecting = 1'b0;
    m_tgt         = '0;
    m_stall_cnt   = 0;
    m_jump_cnt    = 0;
  endtask

  task automatic expect_comb(input bit mem, ld, sif, jf);
    e_stall = 6'd0;
    e_flush = 6'd0;
    if (mem)                e_stall = 6'b011111;
    else if (m_redirecting) e_flush = 6'b000010;
    else if (m_wait_if) begin e_stall = 6'b000001; e_flush = 6'b000110; end
    else if (jf)            e_flush = 6'b000110;
    else if (ld)        begin e_stall = 6'b000111; e_flush = 6'b000100; end
    else if (sif)           e_stall = 6'b000011;
  endtask

  // One clock: drive, check outputs mid-cycle, then advance the model across the edge.
  task automatic cyc(input bit mem, ld, sif, ifb, jf, input logic [31:0] addr);
    bit accept;
    @(negedge clk);
    pif.stallreq_mem = mem;
    pif.stallreq_ld  = ld;
    pif.stallreq_if  = sif;
    pif.if_busy      = ifb;
    pif.ex_jump_flag = jf;
    pif.ex_jump_addr = addr;
    #2;
    expect_comb(mem, ld, sif, jf);
    o_stall = pif.stall; o_flush = pif.flush;
    o_rv = pif.redirect_valid; o_ra = pif.redirect_addr;
    $display("cyc mem=%0b ld=%0b if=%0b busy=%0b jf=%0b addr=%h | stall=%b flush=%b rv=%0b ra=%h",
             mem, ld, sif, ifb, jf, addr, o_stall, o_flush, o_rv, o_ra);
    chk("stall", {26'd0, o_stall}, {26'd0, e_stall});
    chk("flush", {26'd0, o_flush}, {26'd0, e_flush});
    chk("redirect_valid", {31'd0, o_rv}, {31'd0, m_redirecting});
    chk("redirect_addr", o_ra, m_tgt);
`ifdef PIPE_CTRL_PERF_EN
    chk("stall_cycles", {24'd0, pif.stall_cycles}, m_stall_cnt);
    chk("flush_count", {24'd0, pif.flush_count}, m_jump_cnt);
`endif
    @(posedge clk);
    accept = !mem && !m_wait_if && !m_redirecting && jf;
    if (e_stall != 6'd0 && m_stall_cnt < (1 << CNT_LEN) - 1) m_stall_cnt++;
    if (accept && m_jump_cnt < (1 << CNT_LEN) - 1) m_jump_cnt++;
    if (m_redirecting) begin
      if (!mem) m_redirecting = 1'b0;
    end else if (m_wait_if) begin
      if (!ifb) begin m_wait_if = 1'b0; m_redirecting = 1'b1; end
    end else if (accept) begin
      m_tgt = addr;
      if (ifb) m_wait_if = 1'b1;
      else     m_redirecting = 1'b1;
    end
  endtask

  initial begin
    pif.stallreq_mem = 1'b1; pif.stallreq_ld = 1'b1; pif.stallreq_if = 1'b1;
    pif.if_busy = 1'b0; pif.ex_jump_flag = 1'b1; pif.ex_jump_addr = 32'hDEAD_BEEF;
    model_reset();
    #12;
    chk("rst_stall", {26'd0, pif.stall}, 32'd0);
    chk("rst_flush", {26'd0, pif.flush}, 32'd0);
    chk("rst_rv", {31'd0, pif.redirect_valid}, 32'd0);
    chk("rst_ra", pif.redirect_addr, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Jump with IF idle
    cyc(0, 0, 0, 0, 1, 32'h100);
    chk("jmp_flush", {26'd0, o_flush}, 32'h06);
    cyc(0, 0, 0, 0, 0, 32'h0);
    chk("jmp_rv", {31'd0, o_rv}, 32'd1);
    chk("jmp_ra", o_ra, 32'h100);
    chk("jmp_redir_flush", {26'd0, o_flush}, 32'h02);
    cyc(0, 0, 0, 0, 0, 32'h0);
    chk("jmp_rv_once", {31'd0, o_rv}, 32'd0);

    // Jump with IF busy for 3 cycles
    cyc(0, 0, 0, 1, 1, 32'h200);
    cyc(0, 0, 0, 1, 1, 32'h999);
    cyc(0, 0, 0, 1, 0, 32'h0);
    chk("wait_stall", {26'd0, o_stall}, 32'h01);
    cyc(0, 0, 0, 0, 0, 32'h0);
    chk("wait_exit_rv", {31'd0, o_rv}, 32'd0);
    cyc(0, 0, 0, 0, 0, 32'h0);
    chk("wait_rv", {31'd0, o_rv}, 32'd1);
    chk("wait_ra", o_ra, 32'h200);
    cyc(0, 0, 0, 0, 0, 32'h0);

    // MEM stall holding off a jump
    cyc(1, 0, 0, 0, 1, 32'h300);
    chk("mem_stall", {26'd0, o_stall}, 32'h1F);
    cyc(1, 0, 0, 0, 1, 32'h300);
    cyc(0, 0, 0, 0, 1, 32'h300);
    chk("mem_accept_flush", {26'd0, o_flush}, 32'h06);
    cyc(0, 0, 0, 0, 1, 32'h300);
    chk("mem_rv", {31'd0, o_rv}, 32'd1);
    cyc(0, 0, 0, 0, 0, 32'h0);

    // Load-use, then load-use together with a jump
    cyc(0, 1, 0, 0, 0, 32'h0);
    chk("ld_stall", {26'd0, o_stall}, 32'h07);
    chk("ld_flush", {26'd0, o_flush}, 32'h04);
    cyc(0, 1, 0, 0, 1, 32'h400);
    chk("ldjmp_stall", {26'd0, o_stall}, 32'h00);
    cyc(0, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 1, 0, 0, 32'h0);
    chk("if_stall", {26'd0, o_stall}, 32'h03);

    // Async reset while waiting on IF
    cyc(0, 0, 0, 1, 1, 32'h500);
    @(negedge clk);
    pif.if_busy = 1'b1; pif.ex_jump_flag = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_stall", {26'd0, pif.stall}, 32'd0);
    chk("arst_flush", {26'd0, pif.flush}, 32'd0);
    chk("arst_rv", {31'd0, pif.redirect_valid}, 32'd0);
    chk("arst_ra", pif.redirect_addr, 32'd0);
    model_reset();
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) < 2, $urandom_range(0, 9) < 3, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
